dcs_switch_ctrl: RTL and testbench

- Single-clock controller that sequences the SEL/SELFORCE inputs of one LIFCL DCS (dynamic clock select) primitive.
- Accepts software switch requests through a valid/ready handshake and enforces settle and minimum-dwell times.
- Monitors heartbeat toggles from both candidate clocks and performs automatic forced failover when the active clock dies.
- Sits in the fabric clock-management logic, clocked by an always-running system clock independent of CLK0/CLK1.

---
 rtl/dcs_switch_ctrl_if.sv | 10 +
 rtl/dcs_switch_ctrl.sv | 122 ++++++++++++
 tb/tb_dcs_switch_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/dcs_switch_ctrl_if.sv
// dcs_switch_ctrl_if: switch request/response handshake bundle
interface dcs_switch_ctrl_if;
    logic req_valid;
    logic req_sel;
    logic req_ready;
    logic rsp_valid;
    logic rsp_err;
    modport master(output req_valid, req_sel, input req_ready, rsp_valid, rsp_err);
    modport slave(input req_valid, req_sel, output req_ready, rsp_valid, rsp_err);
endinterface

// File: rtl/dcs_switch_ctrl.sv
// dcs_switch_ctrl: sequences DCS SEL/SELFORCE with settle/dwell timing and heartbeat-driven failover
module dcs_switch_ctrl #(
    parameter int SETTLE_CYC  = 16,
    parameter int DWELL_CYC   = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    hb0,
    input  logic                    hb1,
    dcs_switch_ctrl_if.slave        bus,
    output logic                    dcs_sel,
    output logic                    dcs_selforce,
    output logic                    cur_sel,
    output logic [1:0]              alive,
    output logic                    failover
);
    typedef enum logic [1:0] {IDLE, SWITCH, DWELL, FORCE} state_t;
    state_t      state_q, state_d;
    logic [1:0]  hb, hb_prev_q, alive_q, alive_d;
    logic [9:0]  wd_q [2];
    logic [9:0]  wd_d [2];
    logic [7:0]  cnt_q, cnt_d;
    logic        dcs_sel_q, dcs_sel_d, selforce_q, selforce_d, cur_sel_q, cur_sel_d;
    logic        rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, failover_q, failover_d;
    logic        fo_trig, accept;
    assign hb = {hb1, hb0};
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            wd_d[n]    = (hb[n] != hb_prev_q[n]) ? 10'd0 : wd_q[n] + 10'(wd_q[n] < 10'(TIMEOUT_CYC));
            alive_d[n] = wd_d[n] < 10'(TIMEOUT_CYC);
        end
    end
    // Losing the active clock pre-empts both new requests and the dwell period
    assign fo_trig       = (state_q == IDLE || state_q == DWELL) && !alive_q[cur_sel_q] && alive_q[~cur_sel_q];
    assign bus.req_ready = rst_n && state_q == IDLE && !fo_trig;
    assign accept        = bus.req_valid && bus.req_ready;
    always_comb begin
        state_d     = state_q;
        cnt_d       = (state_q == IDLE) ? 8'd0 : cnt_q + 8'd1;
        dcs_sel_d   = dcs_sel_q;
        selforce_d  = selforce_q;
        cur_sel_d   = cur_sel_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        failover_d  = 1'b0;
        if (fo_trig) begin
            state_d    = FORCE;
            cnt_d      = 8'd0;
            dcs_sel_d  = ~cur_sel_q;
            selforce_d = 1'b1;
            failover_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    if (!alive_q[bus.req_sel] || bus.req_sel == cur_sel_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = !alive_q[bus.req_sel];
                    end else begin
                        dcs_sel_d = bus.req_sel;
                        state_d   = SWITCH;
                    end
                end
                SWITCH: if (!alive_q[dcs_sel_q] && alive_q[cur_sel_q]) begin
                    state_d     = FORCE;
                    cnt_d       = 8'd0;
                    dcs_sel_d   = cur_sel_q;
                    selforce_d  = 1'b1;
                    failover_d  = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else if (cnt_q == 8'(SETTLE_CYC - 1)) begin
                    cur_sel_d   = dcs_sel_q;
                    rsp_valid_d = 1'b1;
                    cnt_d       = 8'd0;
                    state_d     = (DWELL_CYC == 0) ? IDLE : DWELL;
                end
                DWELL: state_d = (cnt_q == 8'(DWELL_CYC - 1)) ? IDLE : DWELL;
                FORCE: if (cnt_q == 8'(SETTLE_CYC - 1)) begin
                    cur_sel_d  = dcs_sel_q;
                    selforce_d = 1'b0;
                    cnt_d      = 8'd0;
                    state_d    = (DWELL_CYC == 0) ? IDLE : DWELL;
                end
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hb_prev_q   <= hb;
            wd_q        <= '{default: '0};
            alive_q     <= 2'b11;
            cnt_q       <= 8'd0;
            dcs_sel_q   <= 1'b0;
            selforce_q  <= 1'b0;
            cur_sel_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            failover_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hb_prev_q   <= hb;
            wd_q        <= wd_d;
            alive_q     <= alive_d;
            cnt_q       <= cnt_d;
            dcs_sel_q   <= dcs_sel_d;
            selforce_q  <= selforce_d;
            cur_sel_q   <= cur_sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            failover_q  <= failover_d;
        end
    end
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign dcs_sel       = dcs_sel_q;
    assign dcs_selforce  = selforce_q;
    assign cur_sel       = cur_sel_q;
    assign alive         = alive_q;
    assign failover      = failover_q;
endmodule

// File: tb/tb_dcs_switch_ctrl.sv
// tb_dcs_switch_ctrl: directed checks of switching, rejection, failover and reset with a response scoreboard
module tb_dcs_switch_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hb0, hb1;
    logic [1:0] hb_en = 2'b11;
    logic       dcs_sel, dcs_selforce, cur_sel, failover;
    logic [1:0] alive;
    logic       exp_q [$];
    int         n_cmp = 0;
    int         n_err = 0;
    dcs_switch_ctrl_if bus ();
    dcs_switch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .hb0(hb0), .hb1(hb1), .bus(bus),
        .dcs_sel(dcs_sel), .dcs_selforce(dcs_selforce), .cur_sel(cur_sel),
        .alive(alive), .failover(failover)
    );
    always #5 clk = ~clk;
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        hb0 = 1'b0;
        hb1 = 1'b0;
        forever begin
            repeat (4) @(negedge clk);
            if (hb_en[0]) hb0 = ~hb0;
            if (hb_en[1]) hb1 = ~hb1;
        end
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic send(input logic s, input logic e);
        bus.req_valid = 1'b1;
        bus.req_sel   = s;
        exp_q.push_back(e);
        for (int i = 0; i < 200 && !bus.req_ready; i++) @(negedge clk);
        chk("accept", {31'd0, bus.req_ready}, 1);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask
    task automatic wait_alive(input logic [1:0] a, input int lim);
        for (int i = 0; i < lim && alive !== a; i++) @(negedge clk);
        chk("alive_wait", {30'd0, alive}, {30'd0, a});
    endtask
    task automatic wait_ready(input int lim);
        for (int i = 0; i < lim && !bus.req_ready; i++) @(negedge clk);
        chk("ready_wait", {31'd0, bus.req_ready}, 1);
    endtask
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid === 1'b1) begin
            chk("rsp_pending", {31'd0, exp_q.size() > 0}, 1);
            if (exp_q.size() > 0) chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, exp_q.pop_front()});
        end
    end
    initial begin
        bus.req_valid = 1'b0;
        bus.req_sel   = 1'b0;
        tick(3);
        chk("rst_outs", {26'd0, dcs_sel, dcs_selforce, cur_sel, bus.req_ready, bus.rsp_valid, failover}, 0);
        chk("rst_alive", {30'd0, alive}, 2'b11);
        rst_n = 1'b1;
        tick(2);
        chk("idle_ready", {31'd0, bus.req_ready}, 1);
        // request-initiated switch to CLK1
        send(1'b1, 1'b0);
        chk("sw_dcs_sel", {31'd0, dcs_sel}, 1);
        chk("sw_ready", {31'd0, bus.req_ready}, 0);
        tick(15);
        chk("sw_settling", {30'd0, cur_sel, bus.rsp_valid}, 2'b00);
        tick(1);
        chk("sw_done", {29'd0, cur_sel, bus.rsp_valid, bus.req_ready}, 3'b110);
        tick(1);
        chk("sw_rsp_pulse", {31'd0, bus.rsp_valid}, 0);
        tick(30);
        chk("dwell_end_ready", {31'd0, bus.req_ready}, 0);
        tick(1);
        chk("dwell_exit_ready", {31'd0, bus.req_ready}, 1);
        // request for the already-selected clock
        send(1'b1, 1'b0);
        chk("same_rsp", {30'd0, bus.rsp_valid, dcs_sel}, 2'b11);
        tick(1);
        chk("same_ready", {30'd0, bus.rsp_valid, bus.req_ready}, 2'b01);
        send(1'b0, 1'b0);
        tick(48);
        chk("back_to0", {30'd0, cur_sel, bus.req_ready}, 2'b01);
        // dead target rejected
        hb_en[1] = 1'b0;
        tick(50);
        chk("hb1_not_yet_dead", {30'd0, alive}, 2'b11);
        wait_alive(2'b01, 100);
        send(1'b1, 1'b1);
        chk("rej_rsp", {30'd0, bus.rsp_valid, dcs_sel}, 2'b10);
        hb_en[1] = 1'b1;
        wait_alive(2'b11, 20);
        // automatic failover from CLK0
        hb_en[0] = 1'b0;
        for (int i = 0; i < 200 && failover !== 1'b1; i++) @(negedge clk);
        chk("fo_pulse", {31'd0, failover}, 1);
        chk("fo_entry", {28'd0, dcs_sel, dcs_selforce, cur_sel, bus.req_ready}, 4'b1100);
        tick(1);
        chk("fo_pulse_end", {30'd0, failover, dcs_selforce}, 2'b01);
        tick(14);
        chk("fo_hold", {30'd0, dcs_selforce, cur_sel}, 2'b10);
        tick(1);
        chk("fo_done", {29'd0, dcs_selforce, cur_sel, bus.req_ready}, 3'b010);
        hb_en[0] = 1'b1;
        wait_ready(60);
        wait_alive(2'b11, 20);
        // failover and request in the same idle cycle
        hb_en[1] = 1'b0;
        wait_alive(2'b01, 200);
        bus.req_valid = 1'b1;
        bus.req_sel   = 1'b0;
        chk("fo_req_ready", {31'd0, bus.req_ready}, 0);
        exp_q.push_back(1'b0);
        tick(1);
        chk("fo_req_force", {29'd0, failover, dcs_sel, dcs_selforce}, 3'b101);
        wait_ready(80);
        tick(1);
        bus.req_valid = 1'b0;
        chk("fo_req_later", {30'd0, bus.rsp_valid, cur_sel}, 2'b10);
        hb_en[1] = 1'b1;
        wait_alive(2'b11, 20);
        // target dies mid-switch: forced back to CLK0
        hb_en[1] = 1'b0;
        tick(52);
        send(1'b1, 1'b1);
        chk("abort_switching", {30'd0, dcs_sel, dcs_selforce}, 2'b10);
        for (int i = 0; i < 40 && failover !== 1'b1; i++) @(negedge clk);
        chk("abort_force", {27'd0, failover, bus.rsp_valid, dcs_sel, dcs_selforce, cur_sel}, 5'b11010);
        hb_en[1] = 1'b1;
        wait_ready(80);
        chk("abort_final", {30'd0, cur_sel, dcs_sel}, 2'b00);
        wait_alive(2'b11, 20);
        // reset in the middle of a switch
        send(1'b1, 1'b0);
        exp_q.delete();
        tick(5);
        rst_n = 1'b0;
        tick(1);
        chk("midrst_outs", {26'd0, dcs_sel, dcs_selforce, cur_sel, bus.req_ready, bus.rsp_valid, failover}, 0);
        chk("midrst_alive", {30'd0, alive}, 2'b11);
        rst_n = 1'b1;
        tick(30);
        chk("midrst_idle", {29'd0, bus.req_ready, cur_sel, dcs_sel}, 3'b100);
        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
